// File: rtl/ma_pkg.sv
// ma_pkg: constants and types shared by the memory-access datamovers.
// Beat size, 4 KB page limits, AXI encodings and the store FSM states.
package ma_pkg;

    localparam int VRF_BEAT_BYTES = 128;
    localparam int BEAT_SHIFT     = $clog2(VRF_BEAT_BYTES);
    localparam int AXI_4K_BEATS   = 32;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
    localparam logic [2:0] AXI_SIZE_128B  = 3'b111;

    typedef enum logic [2:0] {
        DM_STR_IDLE,
        DM_STR_AW,
        DM_STR_W,
        DM_STR_B,
        DM_STR_DONE
    } dm_str_state_e;

    // Beats in the next burst: limited by what remains and by the 4 KB page.
    function automatic logic [5:0] burst_beats(
        input logic [7:0] rem,
        input logic [4:0] page_beat
    );
        logic [5:0] room;
        room = 6'(AXI_4K_BEATS) - {1'b0, page_beat};
        if (rem < {2'b00, room}) begin
            return rem[5:0];
        end
        return room;
    endfunction

endpackage

// File: rtl/ma_dm_fifo2.sv
// ma_dm_fifo2: 2-entry FIFO with valid/ready on both sides and a count.
// An empty FIFO passes input straight to output so a steady stream has no bubble.
module ma_dm_fifo2 #(
    parameter int W = 1024
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [W-1:0] in_data_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [W-1:0] out_data_o,
    output logic [1:0]   count_o
);

    logic [W-1:0] mem_q [2];
    logic         wr_ptr_q;
    logic         rd_ptr_q;
    logic [1:0]   count_q;
    logic [1:0]   count_d;
    logic         empty;
    logic         bypass;
    logic         store;
    logic         deq;

    assign empty       = (count_q == 2'd0);
    assign in_ready_o  = (count_q != 2'd2);
    assign out_valid_o = !empty || in_valid_i;
    assign count_o     = count_q;

    always_comb begin
        out_data_o = '0;
        if (!empty) begin
            out_data_o = mem_q[rd_ptr_q];
        end else if (in_valid_i) begin
            out_data_o = in_data_i;
        end
    end

    assign bypass  = empty && out_ready_i;
    assign store   = in_valid_i && in_ready_o && !bypass;
    assign deq     = !empty && out_ready_i;
    assign count_d = count_q + {1'b0, store} - {1'b0, deq};

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (store) begin
                mem_q[wr_ptr_q] <= in_data_i;
                wr_ptr_q        <= !wr_ptr_q;
            end
            if (deq) begin
                rd_ptr_q <= !rd_ptr_q;
            end
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/ma_dm_vrf_str.sv
// ma_dm_vrf_str: streams VRF rows to DDR4 as AXI4 INCR write bursts.
// One burst in flight; bursts are split so none crosses a 4 KB page.
module ma_dm_vrf_str
    import ma_pkg::*;
#(
    parameter int DDR4_ADDRWIDTH = 36,
    parameter int VRF_ADDRWIDTH  = 10,
    parameter int VRF_DATAWIDTH  = 1024
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start_i,
    input  logic [DDR4_ADDRWIDTH-1:0]   dst_axi_addr_i,
    input  logic [VRF_ADDRWIDTH-1:0]    src_bram_addr_i,
    input  logic [14:0]                 byte_to_trans_i,
    output logic                        done_o,
    output logic                        err_o,
    output logic                        busy_o,
    output logic                        vrf_en_o,
    output logic [VRF_ADDRWIDTH-1:0]    vrf_addr_o,
    input  logic [VRF_DATAWIDTH-1:0]    vrf_dout_i,
    output logic [DDR4_ADDRWIDTH-1:0]   m_axi_awaddr,
    output logic [7:0]                  m_axi_awlen,
    output logic [2:0]                  m_axi_awsize,
    output logic [1:0]                  m_axi_awburst,
    output logic                        m_axi_awvalid,
    input  logic                        m_axi_awready,
    output logic [VRF_DATAWIDTH-1:0]    m_axi_wdata,
    output logic [VRF_DATAWIDTH/8-1:0]  m_axi_wstrb,
    output logic                        m_axi_wlast,
    output logic                        m_axi_wvalid,
    input  logic                        m_axi_wready,
    input  logic [1:0]                  m_axi_bresp,
    input  logic                        m_axi_bvalid,
    output logic                        m_axi_bready
);

    dm_str_state_e              state_q, state_d;
    logic [DDR4_ADDRWIDTH-1:0]  cur_addr_q, cur_addr_d;
    logic [VRF_ADDRWIDTH-1:0]   rd_ptr_q, rd_ptr_d;
    logic [7:0]                 rem_q, rem_d;
    logic                       err_q, err_d;
    logic [5:0]                 burst_n_q, burst_n_d;
    logic [5:0]                 rd_left_q, rd_left_d;
    logic [5:0]                 wcnt_q, wcnt_d;
    logic                       infl_q;

    logic [5:0]                 burst_n;
    logic [7:0]                 beats_in;
    logic                       rd_fire;
    logic                       fifo_vld;
    logic                       fifo_out_rdy;
    logic                       fifo_in_rdy;
    logic [1:0]                 fifo_cnt;
    logic                       unused_bits;

    assign beats_in = byte_to_trans_i[14:7];
    assign burst_n  = burst_beats(rem_q, cur_addr_q[11:7]);

    assign m_axi_awaddr  = cur_addr_q;
    assign m_axi_awsize  = AXI_SIZE_128B;
    assign m_axi_awburst = AXI_BURST_INCR;
    assign m_axi_wstrb   = '1;
    assign vrf_addr_o    = rd_ptr_q;

    // Keep FIFO occupancy plus the read in flight within the two slots.
    assign rd_fire = (state_q == DM_STR_W) && (rd_left_q != 6'd0)
                   && (({1'b0, fifo_cnt} + {2'b00, infl_q}) < 3'd2);

    assign fifo_out_rdy = m_axi_wready && (state_q == DM_STR_W);

    assign unused_bits = ^{dst_axi_addr_i[6:0], byte_to_trans_i[6:0],
                           fifo_in_rdy};

    ma_dm_fifo2 #(
        .W(VRF_DATAWIDTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .in_valid_i (infl_q),
        .in_ready_o (fifo_in_rdy),
        .in_data_i  (vrf_dout_i),
        .out_valid_o(fifo_vld),
        .out_ready_i(fifo_out_rdy),
        .out_data_o (m_axi_wdata),
        .count_o    (fifo_cnt)
    );

    always_comb begin
        state_d       = state_q;
        cur_addr_d    = cur_addr_q;
        rd_ptr_d      = rd_ptr_q;
        rem_d         = rem_q;
        err_d         = err_q;
        burst_n_d     = burst_n_q;
        rd_left_d     = rd_left_q;
        wcnt_d        = wcnt_q;
        m_axi_awvalid = 1'b0;
        m_axi_awlen   = 8'd0;
        m_axi_wvalid  = 1'b0;
        m_axi_wlast   = 1'b0;
        m_axi_bready  = 1'b0;
        vrf_en_o      = 1'b0;
        done_o        = 1'b0;
        err_o         = 1'b0;
        busy_o        = (state_q != DM_STR_IDLE);

        unique case (state_q)
            DM_STR_IDLE: begin
                if (start_i) begin
                    cur_addr_d = {dst_axi_addr_i[DDR4_ADDRWIDTH-1:7], 7'b0};
                    rd_ptr_d   = src_bram_addr_i;
                    rem_d      = beats_in;
                    err_d      = 1'b0;
                    state_d    = (beats_in == 8'd0) ? DM_STR_DONE : DM_STR_AW;
                end
            end
            DM_STR_AW: begin
                m_axi_awvalid = 1'b1;
                m_axi_awlen   = {2'b00, burst_n} - 8'd1;
                if (m_axi_awready) begin
                    cur_addr_d = cur_addr_q
                               + (DDR4_ADDRWIDTH'(burst_n) << BEAT_SHIFT);
                    rem_d      = rem_q - {2'b00, burst_n};
                    burst_n_d  = burst_n;
                    rd_left_d  = burst_n;
                    wcnt_d     = 6'd0;
                    state_d    = DM_STR_W;
                end
            end
            DM_STR_W: begin
                vrf_en_o     = rd_fire;
                m_axi_wvalid = fifo_vld;
                m_axi_wlast  = fifo_vld && (wcnt_q == burst_n_q - 6'd1);
                if (rd_fire) begin
                    rd_ptr_d  = rd_ptr_q + 1'b1;
                    rd_left_d = rd_left_q - 6'd1;
                end
                if (fifo_vld && m_axi_wready) begin
                    wcnt_d = wcnt_q + 6'd1;
                    if (m_axi_wlast) begin
                        state_d = DM_STR_B;
                    end
                end
            end
            DM_STR_B: begin
                m_axi_bready = 1'b1;
                if (m_axi_bvalid) begin
                    if (m_axi_bresp != AXI_RESP_OKAY) begin
                        err_d = 1'b1;
                    end
                    state_d = (rem_q != 8'd0) ? DM_STR_AW : DM_STR_DONE;
                end
            end
            DM_STR_DONE: begin
                done_o  = 1'b1;
                err_o   = err_q;
                state_d = DM_STR_IDLE;
            end
            default: begin
                state_d = DM_STR_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= DM_STR_IDLE;
            cur_addr_q <= '0;
            rd_ptr_q   <= '0;
            rem_q      <= 8'd0;
            err_q      <= 1'b0;
            burst_n_q  <= 6'd0;
            rd_left_q  <= 6'd0;
            wcnt_q     <= 6'd0;
            infl_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cur_addr_q <= cur_addr_d;
            rd_ptr_q   <= rd_ptr_d;
            rem_q      <= rem_d;
            err_q      <= err_d;
            burst_n_q  <= burst_n_d;
            rd_left_q  <= rd_left_d;
            wcnt_q     <= wcnt_d;
            infl_q     <= rd_fire;
        end
    end

endmodule

// File: tb/tb_ma_dm_vrf_str.sv
// tb_ma_dm_vrf_str: directed bench for the VRF store datamover.
// Expected AW/W/done items are queued at issue and checked by monitors.
module tb_ma_dm_vrf_str;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start_i = 1'b0;
    logic [35:0]   dst_axi_addr_i = '0;
    logic [9:0]    src_bram_addr_i = '0;
    logic [14:0]   byte_to_trans_i = '0;
    logic          done_o, err_o, busy_o, vrf_en_o;
    logic [9:0]    vrf_addr_o;
    logic [1023:0] vrf_dout_i = '0;
    logic [35:0]   m_axi_awaddr;
    logic [7:0]    m_axi_awlen;
    logic [2:0]    m_axi_awsize;
    logic [1:0]    m_axi_awburst;
    logic          m_axi_awvalid;
    logic          m_axi_awready = 1'b0;
    logic [1023:0] m_axi_wdata;
    logic [127:0]  m_axi_wstrb;
    logic          m_axi_wlast, m_axi_wvalid;
    logic          m_axi_wready = 1'b0;
    logic [1:0]    m_axi_bresp = 2'b00;
    logic          m_axi_bvalid = 1'b0;
    logic          m_axi_bready;

    always #5 clk = ~clk;

    ma_dm_vrf_str dut (
        .clk(clk), .rst(rst), .start_i(start_i),
        .dst_axi_addr_i(dst_axi_addr_i), .src_bram_addr_i(src_bram_addr_i),
        .byte_to_trans_i(byte_to_trans_i), .done_o(done_o), .err_o(err_o),
        .busy_o(busy_o), .vrf_en_o(vrf_en_o), .vrf_addr_o(vrf_addr_o),
        .vrf_dout_i(vrf_dout_i), .m_axi_awaddr(m_axi_awaddr),
        .m_axi_awlen(m_axi_awlen), .m_axi_awsize(m_axi_awsize),
        .m_axi_awburst(m_axi_awburst), .m_axi_awvalid(m_axi_awvalid),
        .m_axi_awready(m_axi_awready), .m_axi_wdata(m_axi_wdata),
        .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
        .m_axi_bready(m_axi_bready)
    );

    typedef struct { logic [35:0] addr; logic [7:0] len; } aw_t;
    typedef struct { logic [1023:0] data; logic last; } w_t;
    typedef struct { logic err; logic has_b; } d_t;

    aw_t        exp_aw[$];
    w_t         exp_w[$];
    d_t         exp_d[$];
    logic [1:0] bresp_q[$];

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int done_cnt = 0;
    int b_cyc = -10;
    int aw_delay = 0;
    int aw_wait = 0;
    int b_pend = 0;
    bit w_rand = 1'b0;
    bit wl_hs_s = 1'b0;
    bit b_hs_s = 1'b0;
    bit prev_awv = 1'b0, prev_awr = 1'b0, prev_wv = 1'b0, prev_wr = 1'b0;
    logic [35:0]   prev_addr;
    logic [7:0]    prev_len;
    logic [1023:0] prev_wd;

    always @(posedge clk) cyc++;

    function automatic logic [1023:0] row(input logic [9:0] a);
        logic [1023:0] r;
        for (int i = 0; i < 32; i++) begin
            r[i*32 +: 32] = {a, 22'(i)} ^ 32'hA5A5_0000;
        end
        return r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", nm, act, exp);
        end
    endtask

    task automatic exp_burst(input logic [35:0] addr, input int n,
                             inout logic [9:0] ptr);
        aw_t a;
        w_t  w;
        a.addr = addr;
        a.len  = 8'(n - 1);
        exp_aw.push_back(a);
        for (int j = 0; j < n; j++) begin
            w.data = row(ptr);
            w.last = (j == n - 1);
            exp_w.push_back(w);
            ptr = ptr + 10'd1;
        end
    endtask

    // VRF BRAM model: one-cycle read latency.
    always @(posedge clk) begin
        if (vrf_en_o) vrf_dout_i <= row(vrf_addr_o);
    end

    // AXI slave driver, stepping 2 time units after each rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (rst) begin
                m_axi_awready = 1'b0;
                m_axi_wready  = 1'b0;
                m_axi_bvalid  = 1'b0;
                b_pend  = 0;
                aw_wait = 0;
            end else begin
                if (wl_hs_s) b_pend++;
                if (b_hs_s) m_axi_bvalid = 1'b0;
                if (!m_axi_bvalid && b_pend > 0) begin
                    m_axi_bvalid = 1'b1;
                    m_axi_bresp  = (bresp_q.size() > 0) ?
                                   bresp_q.pop_front() : 2'b00;
                    b_pend--;
                end
                if (m_axi_awvalid && !m_axi_awready) begin
                    if (aw_wait >= aw_delay) m_axi_awready = 1'b1;
                    else aw_wait++;
                end else begin
                    m_axi_awready = 1'b0;
                    aw_wait = 0;
                end
                m_axi_wready = w_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            end
        end
    end

    // Monitor: compares every handshake and done pulse against the queues.
    always @(negedge clk) begin
        wl_hs_s = 1'b0;
        b_hs_s  = 1'b0;
        if (!rst) begin
            if (prev_awv && !prev_awr) begin
                chk("aw_hold", {m_axi_awvalid, m_axi_awlen, m_axi_awaddr},
                    {1'b1, prev_len, prev_addr});
            end
            if (prev_wv && !prev_wr) begin
                total++;
                if (!m_axi_wvalid || m_axi_wdata !== prev_wd) begin
                    bad++;
                    $display("FAIL w_hold: got=%0h want=%0h",
                             m_axi_wdata[31:0], prev_wd[31:0]);
                end
            end
            if (m_axi_awvalid && m_axi_awready) begin
                if (exp_aw.size() == 0) begin
                    chk("aw_unexpected", m_axi_awaddr, 64'hFFFF_FFFF);
                end else begin
                    aw_t e;
                    e = exp_aw.pop_front();
                    chk("awaddr", m_axi_awaddr, e.addr);
                    chk("awlen", m_axi_awlen, e.len);
                end
            end
            if (m_axi_wvalid && m_axi_wready) begin
                wl_hs_s = m_axi_wlast;
                if (exp_w.size() == 0) begin
                    chk("w_unexpected", m_axi_wdata[31:0], 64'hFFFF_FFFF);
                end else begin
                    w_t e;
                    e = exp_w.pop_front();
                    total++;
                    if (m_axi_wdata !== e.data) begin
                        bad++;
                        $display("FAIL wdata: got=%0h want=%0h",
                                 m_axi_wdata[31:0], e.data[31:0]);
                    end
                    chk("wlast", m_axi_wlast, e.last);
                end
            end
            if (m_axi_bvalid && m_axi_bready) begin
                b_hs_s = 1'b1;
                b_cyc  = cyc;
            end
            if (done_o) begin
                done_cnt++;
                if (exp_d.size() == 0) begin
                    chk("done_unexpected", done_o, 0);
                end else begin
                    d_t e;
                    e = exp_d.pop_front();
                    chk("err_o", err_o, e.err);
                    if (e.has_b) chk("done_after_b", cyc - b_cyc, 1);
                    chk("aw_left", exp_aw.size(), 0);
                    chk("w_left", exp_w.size(), 0);
                end
            end
        end
        prev_awv  = !rst && m_axi_awvalid;
        prev_awr  = m_axi_awready;
        prev_addr = m_axi_awaddr;
        prev_len  = m_axi_awlen;
        prev_wv   = !rst && m_axi_wvalid;
        prev_wr   = m_axi_wready;
        prev_wd   = m_axi_wdata;
    end

    task automatic issue(input logic [35:0] dst, input logic [9:0] src,
                         input logic [14:0] bytes, input logic err,
                         input logic has_b);
        d_t d;
        d.err   = err;
        d.has_b = has_b;
        exp_d.push_back(d);
        dst_axi_addr_i  = dst;
        src_bram_addr_i = src;
        byte_to_trans_i = bytes;
        start_i = 1'b1;
        @(posedge clk);
        #1;
        start_i = 1'b0;
    endtask

    task automatic wait_done(input string nm, input int budget);
        int n;
        n = 0;
        forever begin
            @(negedge clk);
            if (done_o) break;
            n++;
            if (n > budget) begin
                chk({nm, "_timeout"}, 0, 1);
                break;
            end
        end
        @(negedge clk);
        chk({nm, "_busy_off"}, {busy_o, done_o}, 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [9:0] p;
        int d0;
        int n;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ctl", {done_o, err_o, busy_o, vrf_en_o, m_axi_awvalid,
                        m_axi_wvalid, m_axi_wlast, m_axi_bready}, 0);
        chk("rst_aw", {m_axi_awaddr, m_axi_awlen}, 0);
        chk("rst_const", {m_axi_awsize, m_axi_awburst}, {3'b111, 2'b01});
        chk("rst_wstrb", {m_axi_wstrb[127:96], m_axi_wstrb[31:0]},
            64'hFFFF_FFFF_FFFF_FFFF);
        @(posedge clk);
        #1;

        // single 4-beat burst
        p = 10'h010;
        exp_burst(36'h1000, 4, p);
        issue(36'h1000, 10'h010, 15'd512, 1'b0, 1'b1);
        @(negedge clk);
        chk("t1_awvalid_t1", m_axi_awvalid, 1);
        wait_done("t1", 200);

        // page split 0xF80 -> 1 beat + 2 beats
        p = 10'h020;
        exp_burst(36'h0F80, 1, p);
        exp_burst(36'h1000, 2, p);
        issue(36'h0F80, 10'h020, 15'd384, 1'b0, 1'b1);
        wait_done("t2", 200);

        // zero-beat command, start held into the busy cycle
        d0 = done_cnt;
        exp_d.push_back('{err: 1'b0, has_b: 1'b0});
        dst_axi_addr_i  = 36'h3000;
        byte_to_trans_i = 15'h7F;
        start_i = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("t3_done_t1", {done_o, busy_o, m_axi_awvalid}, 3'b110);
        @(posedge clk);
        #1;
        start_i = 1'b0;
        @(negedge clk);
        chk("t3_idle", {done_o, busy_o}, 0);
        repeat (5) @(posedge clk);
        #1;
        chk("t3_one_done", done_cnt - d0, 1);

        // SLVERR on first burst
        bresp_q.push_back(2'b10);
        bresp_q.push_back(2'b00);
        p = 10'h200;
        exp_burst(36'h0F80, 1, p);
        exp_burst(36'h1000, 2, p);
        issue(36'h0F80, 10'h200, 15'd384, 1'b1, 1'b1);
        wait_done("t5", 200);

        // following command clears err
        p = 10'h010;
        exp_burst(36'h1000, 4, p);
        issue(36'h1000, 10'h010, 15'd512, 1'b0, 1'b1);
        wait_done("t5b", 200);

        // long command, slow slave, VRF wrap
        aw_delay = 5;
        w_rand   = 1'b1;
        p = 10'h3F0;
        for (int k = 0; k < 7; k++) exp_burst(36'(k * 36'h1000), 32, p);
        exp_burst(36'h7000, 31, p);
        issue(36'h0, 10'h3F0, 15'd32767, 1'b0, 1'b1);
        repeat (10) @(posedge clk);
        #1;
        dst_axi_addr_i = 36'h5_0000;
        start_i = 1'b1;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        wait_done("t4", 5000);
        chk("t4_wrap_ptr", p, 10'h0EF);

        // reset during W
        aw_delay = 0;
        p = 10'h100;
        exp_burst(36'h2000, 4, p);
        issue(36'h2000, 10'h100, 15'd512, 1'b0, 1'b1);
        n = 0;
        forever begin
            @(negedge clk);
            if (m_axi_wvalid && m_axi_wready) break;
            n++;
            if (n > 200) begin
                chk("t6_w_timeout", 0, 1);
                break;
            end
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        exp_aw.delete();
        exp_w.delete();
        exp_d.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("t6_after_rst", {m_axi_awvalid, m_axi_wvalid, vrf_en_o,
                             m_axi_bready, done_o, busy_o}, 0);
        d0 = done_cnt;
        repeat (20) @(posedge clk);
        #1;
        chk("t6_no_done", done_cnt - d0, 0);
        w_rand = 1'b0;
        p = 10'h040;
        exp_burst(36'h4000, 4, p);
        issue(36'h4000, 10'h040, 15'd512, 1'b0, 1'b1);
        wait_done("t6b", 200);

        chk("end_q", {16'(exp_aw.size()), 16'(exp_w.size()),
                      16'(exp_d.size())}, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
